// File: rtl/apb_master.sv
// apb_master: APB3 requester bridging single-word commands from the local
// controller onto PSELx/PENABLE. It returns read data and error status on a
// one-cycle response strobe and aborts an access whose wait states run too long.
module apb_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  // command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response side
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // APB side
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // The counter holds the index of the current ACCESS cycle (0-based), so the
  // TIMEOUT-th cycle is the one where it equals TIMEOUT-1.
  localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit              TO_EN   = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    accept_s;

  // Command acceptance: idle, or on the completing ACCESS edge for back-to-back.
  always_comb begin
    cmd_ready = !PRESET && ((state_q == IDLE) || ((state_q == ACCESS) && PREADY));
    accept_s  = cmd_valid && cmd_ready;
  end

  // Next-state and next-output computation for the transfer FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = {DATA_WIDTH{1'b0}};
    rsp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (accept_s) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_write ? cmd_wdata : {DATA_WIDTH{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
        cnt_d     = {CNT_W{1'b0}};
      end

      ACCESS: begin
        if (PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? {DATA_WIDTH{1'b0}} : PRDATA;
          rsp_err_d   = PSLVERR;
          penable_d   = 1'b0;
          if (accept_s) begin
            // Back-to-back: stay selected and go straight into the next SETUP.
            state_d  = SETUP;
            psel_d   = 1'b1;
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_write ? cmd_wdata : {DATA_WIDTH{1'b0}};
          end else begin
            state_d = IDLE;
            psel_d  = 1'b0;
          end
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          // Slave never answered: abort and report an error with no data.
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end

      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= {ADDR_WIDTH{1'b0}};
      pwdata_q    <= {DATA_WIDTH{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_WIDTH{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT=4) with a small memory-backed slave.
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSELx, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  int errors = 0;
  int checks = 0;

  // slave model: memory backing, or a forced read value
  logic [31:0] mem [16];
  logic        use_mem;
  logic [31:0] prdata_force;

  assign PRDATA = use_mem ? mem[PADDR[3:0]] : prdata_force;

  always @(posedge PCLK) begin
    if (PSELx && PENABLE && PREADY && PWRITE) mem[PADDR[3:0]] <= PWDATA;
  end

  always #5 PCLK = ~PCLK;

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 32'h0; cmd_wdata = 32'h0;
    PREADY = 1'b0; PSLVERR = 1'b0; use_mem = 1'b1; prdata_force = 32'h0;
    step(); step();

    // reset state
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk("rst_psel", {31'h0, PSELx}, 32'h0);
    chk("rst_penable", {31'h0, PENABLE}, 32'h0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    PRESET = 1'b0;
    #1;
    chk("idle_cmd_ready", {31'h0, cmd_ready}, 32'h1);

    // 1: write 6 / DEADBEEF, zero wait states
    PREADY = 1'b1;
    cmd(1'b1, 32'h6, 32'hDEAD_BEEF);
    step();
    cmd_valid = 1'b0;
    chk("wr_setup_psel", {31'h0, PSELx}, 32'h1);
    chk("wr_setup_pen", {31'h0, PENABLE}, 32'h0);
    chk("wr_setup_paddr", PADDR, 32'h6);
    chk("wr_setup_pwrite", {31'h0, PWRITE}, 32'h1);
    chk("wr_setup_pwdata", PWDATA, 32'hDEAD_BEEF);
    chk("wr_setup_ready", {31'h0, cmd_ready}, 32'h0);
    chk("wr_setup_rsp", {31'h0, rsp_valid}, 32'h0);
    step();
    chk("wr_access_psel", {31'h0, PSELx}, 32'h1);
    chk("wr_access_pen", {31'h0, PENABLE}, 32'h1);
    chk("wr_access_rsp", {31'h0, rsp_valid}, 32'h0);
    step();
    chk("wr_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("wr_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("wr_rsp_rdata", rsp_rdata, 32'h0);
    chk("wr_done_psel", {31'h0, PSELx}, 32'h0);
    step();
    chk("wr_rsp_once", {31'h0, rsp_valid}, 32'h0);
    chk("wr_mem", mem[6], 32'hDEAD_BEEF);

    // 2: read 7 with three wait states
    PREADY = 1'b0; use_mem = 1'b0; prdata_force = 32'd817;
    cmd(1'b0, 32'h7, 32'h1234_5678);
    step();
    cmd_valid = 1'b0;
    chk("rd_setup_pwdata", PWDATA, 32'h0);
    chk("rd_setup_pwrite", {31'h0, PWRITE}, 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_pen", {31'h0, PENABLE}, 32'h1);
      chk("rd_wait_paddr", PADDR, 32'h7);
      chk("rd_wait_pwrite", {31'h0, PWRITE}, 32'h0);
      chk("rd_wait_rsp", {31'h0, rsp_valid}, 32'h0);
      step();
    end
    chk("rd_last_paddr", PADDR, 32'h7);
    chk("rd_last_pen", {31'h0, PENABLE}, 32'h1);
    PREADY = 1'b1;
    step();
    chk("rd_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("rd_rsp_rdata", rsp_rdata, 32'd817);
    chk("rd_rsp_err", {31'h0, rsp_err}, 32'h0);

    // 3: back-to-back write 6 then read 6
    use_mem = 1'b1;
    cmd(1'b1, 32'h6, 32'hCAFE_F00D);
    step();
    chk("b2b_s1_psel", {31'h0, PSELx}, 32'h1);
    chk("b2b_s1_pen", {31'h0, PENABLE}, 32'h0);
    chk("b2b_s1_pwrite", {31'h0, PWRITE}, 32'h1);
    cmd(1'b0, 32'h6, 32'h0);
    step();
    chk("b2b_a1_psel", {31'h0, PSELx}, 32'h1);
    chk("b2b_a1_pen", {31'h0, PENABLE}, 32'h1);
    chk("b2b_a1_ready", {31'h0, cmd_ready}, 32'h1);
    step();
    cmd_valid = 1'b0;
    chk("b2b_s2_psel", {31'h0, PSELx}, 32'h1);
    chk("b2b_s2_pen", {31'h0, PENABLE}, 32'h0);
    chk("b2b_s2_pwrite", {31'h0, PWRITE}, 32'h0);
    chk("b2b_wr_rsp", {31'h0, rsp_valid}, 32'h1);
    step();
    chk("b2b_a2_psel", {31'h0, PSELx}, 32'h1);
    chk("b2b_a2_pen", {31'h0, PENABLE}, 32'h1);
    chk("b2b_gap_rsp", {31'h0, rsp_valid}, 32'h0);
    step();
    chk("b2b_rd_rsp", {31'h0, rsp_valid}, 32'h1);
    chk("b2b_rd_data", rsp_rdata, 32'hCAFE_F00D);
    chk("b2b_end_psel", {31'h0, PSELx}, 32'h0);

    // 4: read with slave error
    use_mem = 1'b0; prdata_force = 32'h0BAD_0001; PSLVERR = 1'b1;
    cmd(1'b0, 32'h3, 32'h0);
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("err_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("err_rsp_err", {31'h0, rsp_err}, 32'h1);
    chk("err_rsp_rdata", rsp_rdata, 32'h0BAD_0001);
    PSLVERR = 1'b0;

    // 5: timeout after 4 ACCESS cycles
    PREADY = 1'b0; prdata_force = 32'h0000_0055;
    cmd(1'b0, 32'h9, 32'h0);
    step();
    cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_pen", {31'h0, PENABLE}, 32'h1);
      chk("to_wait_rsp", {31'h0, rsp_valid}, 32'h0);
      chk("to_wait_ready", {31'h0, cmd_ready}, 32'h0);
      step();
    end
    chk("to_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("to_rsp_err", {31'h0, rsp_err}, 32'h1);
    chk("to_rsp_rdata", rsp_rdata, 32'h0);
    chk("to_psel", {31'h0, PSELx}, 32'h0);
    chk("to_pen", {31'h0, PENABLE}, 32'h0);
    step();
    chk("to_rsp_once", {31'h0, rsp_valid}, 32'h0);
    chk("to_idle_ready", {31'h0, cmd_ready}, 32'h1);

    // 6: reset during ACCESS, then a normal transfer
    cmd(1'b1, 32'h5, 32'h0000_0011);
    step();
    cmd_valid = 1'b0;
    step();
    chk("rstmid_pen", {31'h0, PENABLE}, 32'h1);
    PRESET = 1'b1; PREADY = 1'b1;
    step();
    chk("rstmid_psel", {31'h0, PSELx}, 32'h0);
    chk("rstmid_pen0", {31'h0, PENABLE}, 32'h0);
    chk("rstmid_paddr", PADDR, 32'h0);
    chk("rstmid_rsp", {31'h0, rsp_valid}, 32'h0);
    chk("rstmid_ready", {31'h0, cmd_ready}, 32'h0);
    PRESET = 1'b0;
    step();
    chk("rstmid_no_rsp", {31'h0, rsp_valid}, 32'h0);
    use_mem = 1'b1;
    cmd(1'b0, 32'h6, 32'h0);
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("post_rst_rsp", {31'h0, rsp_valid}, 32'h1);
    chk("post_rst_data", rsp_rdata, 32'hCAFE_F00D);
    chk("post_rst_err", {31'h0, rsp_err}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
APB requester (bridge) for the UART controller. It converts single-word commands from the local controller into APB3 transfers on the PSELx/PENABLE bus toward the APB slave register/memory block. It returns read data and error status on a one-cycle response strobe. It supports wait states, back-to-back transfers and a bounded wait timeout.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr/PADDR
DATA_WIDTH, 32, width of write/read data paths
TIMEOUT, 16, max consecutive ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
PCLK  input  1  clock, all logic on rising edge
PRESET  input  1  synchronous reset, active-high
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid&cmd_ready at rising edge
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_WIDTH  transfer address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle completion strobe, no backpressure
rsp_rdata  output  DATA_WIDTH  read data (0 for writes and timeouts)
rsp_err  output  1  PSLVERR sampled at completion, or timeout
PSELx  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PADDR  output  ADDR_WIDTH  APB address
PWDATA  output  DATA_WIDTH  APB write data
PREADY  input  1  slave ready
PRDATA  input  DATA_WIDTH  slave read data
PSLVERR  input  1  slave error

Behaviour:
- Reset: PRESET sampled high at a rising edge forces state IDLE. All registered outputs go to 0: PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err. The timeout counter clears. cmd_ready=0 while PRESET high. Reset mid-transfer abandons the transfer: no rsp_valid, PSELx drops on the next edge.
- States: IDLE, SETUP, ACCESS. All APB outputs are registered.
- cmd_ready (combinational) = !PRESET & ((state==IDLE) | (state==ACCESS & PREADY)).
- IDLE: PSELx=0, PENABLE=0, and the address/data outputs hold their last values. On accept, latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA and go to SETUP. PWDATA is driven 0 when cmd_write=0.
- SETUP: PSELx=1, PENABLE=0. Lasts exactly one cycle, then ACCESS unconditionally.
- ACCESS: PSELx=1, PENABLE=1. PADDR/PWRITE/PWDATA stay stable from SETUP through the end of ACCESS.
- Wait states: PREADY low keeps the block in ACCESS with all outputs unchanged, and the counter increments.
- Completion: PREADY high at a rising edge in ACCESS. In the following cycle:
  - rsp_valid=1 for exactly one cycle.
  - rsp_rdata = PRDATA sampled at that edge if read, else 0.
  - rsp_err = PSLVERR sampled at that edge.
- After completion:
  - If a command was accepted on the same edge, go to SETUP with PSELx held at 1 and PENABLE=0, and latch the new command.
  - Otherwise go to IDLE with PSELx=0 and PENABLE=0.
- Latency: accept at edge N gives SETUP in cycle N+1 and ACCESS in cycle N+2. With zero wait states, rsp_valid is high in cycle N+3. Back-to-back throughput is one transfer per 2 cycles.
- Timeout (TIMEOUT>0): the counter resets on entry to ACCESS. If PREADY is still low on the TIMEOUT-th ACCESS cycle:
  - Abort the transfer and go to IDLE. PSELx and PENABLE are 0 next cycle.
  - rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - cmd_ready is low on the abort edge, so there is no back-to-back transfer after a timeout.
- PREADY and PSLVERR are ignored outside ACCESS. PSLVERR is only meaningful with PREADY=1.
- rsp_valid and a new accept can coincide; there is no interaction between the two.

Test Plan:
- Reset, write 0x0000_0006 / 0xDEAD_BEEF, slave PREADY=1 in first ACCESS -> SETUP cycle N+1 with PSELx=1 and PENABLE=0; ACCESS cycle N+2; rsp_valid high cycle N+3 with rsp_err=0 and rsp_rdata=0; PSELx=0 after.
- Read addr 7 with PREADY held low 3 ACCESS cycles, then PRDATA=817 with PREADY=1 -> PADDR/PWRITE stable for all 4 ACCESS cycles; rsp_rdata=817, rsp_err=0.
- cmd_valid held high for write 6 then read 6, zero wait states -> PSELx continuously 1; PENABLE sequence 0,1,0,1; rsp_valid pulses 2 cycles apart; read returns written value.
- Read with PREADY=1 and PSLVERR=1 -> rsp_valid=1, rsp_err=1, rsp_rdata=PRDATA sampled.
- TIMEOUT=4, PREADY never asserted -> after 4 ACCESS cycles: rsp_valid=1, rsp_err=1, rsp_rdata=0; next state IDLE.
- PRESET asserted during ACCESS -> next cycle PSELx, PENABLE, PADDR and rsp_valid all 0; no response; a new command after release completes normally.
